pc_unit_ras: RTL and testbench

Parametrised program-counter unit with a hardware return-address stack (RAS) and a valid/ready fetch handshake toward instruction memory. It is the next-generation PC block of the single-cycle RISC-V core. It adds configurable reset vector, instruction stride and call/return support to the existing halt, jump and conditional-jump behaviour. It sits between the control/ALU outputs and the instruction-memory address port.

---
 rtl/pc_unit_ras_pkg.sv | 22 ++
 rtl/pc_unit_ras_if.sv | 40 ++++
 rtl/pc_unit_ras_ret_addr_stack.sv | 84 ++++++++
 rtl/pc_unit_ras.sv | 96 +++++++++
 tb/tb_pc_unit_ras.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_ras_pkg.sv
// Shared definitions for the program-counter unit with return-address stack.
//   pc_sel_t   : next-PC source select (sequential, PC-relative, stack top)
//   ras_ptr_w  : width of the circular stack pointer for a given depth
//   DEF_*      : default parameter values used by the PC unit
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_REL = 2'd1,
    SEL_RAS = 2'd2
  } pc_sel_t;

  localparam int DEF_PC_WIDTH    = 32;
  localparam int DEF_INSTR_BYTES = 4;
  localparam int DEF_RAS_DEPTH   = 4;

  // Pointer width for the circular stack; a depth of 1 still needs one bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control and fetch bundle of the PC unit.
//   Control inputs : halt, jmp, jmp_if, alu_out_lsb, call, ret, imm_padded_out
//   Fetch handshake: fetch_valid (PC unit -> memory), fetch_ready (memory -> PC unit),
//                    next_instr_addr (address presented with fetch_valid)
//   Status         : ras_count, ras_overflow, ras_underflow
// Handshake: an address transfer happens on a rising edge where fetch_valid and
// fetch_ready are both high (and halt is low); while fetch_valid is high and
// fetch_ready is low the address is held stable and never retracted.
// modport slave is the PC unit; modport master is the core/memory side.
interface pc_unit_ras_if #(
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic                halt;
  logic                jmp;
  logic                jmp_if;
  logic                alu_out_lsb;
  logic                call;
  logic                ret;
  logic [PC_WIDTH-1:0] imm_padded_out;
  logic                fetch_ready;
  logic                fetch_valid;
  logic [PC_WIDTH-1:0] next_instr_addr;
  logic [CNT_W-1:0]    ras_count;
  logic                ras_overflow;
  logic                ras_underflow;

  modport slave (
    input  halt, jmp, jmp_if, alu_out_lsb, call, ret, imm_padded_out, fetch_ready,
    output fetch_valid, next_instr_addr, ras_count, ras_overflow, ras_underflow
  );

  modport master (
    output halt, jmp, jmp_if, alu_out_lsb, call, ret, imm_padded_out, fetch_ready,
    input  fetch_valid, next_instr_addr, ras_count, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_unit_ras_ret_addr_stack.sv
// Circular return-address stack.
//   clk, rst   : clock and asynchronous active-high reset (empties the stack)
//   push, pop  : push push_data / pop top; both together swap the top entry
//   push_data  : return address to store
//   top        : current top entry (combinational, same cycle)
//   empty      : no live entries
//   count      : live entries, saturates at RAS_DEPTH
//   overflow   : sticky, a push happened while full
//   underflow  : sticky, a pop happened while empty
module ret_addr_stack
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [PC_WIDTH-1:0]           push_data,
  output logic [PC_WIDTH-1:0]           top,
  output logic                          empty,
  output logic [ras_ptr_w(RAS_DEPTH):0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
  // wr_ptr is the next free slot; the top entry sits just below it.
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    top_idx;
  logic                full;

  assign top_idx = wr_ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push && pop) begin
      // Swap keeps the depth; on an empty stack it degrades to a plain push.
      if (empty) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        count     <= CNT_W'(1);
        underflow <= 1'b1;
      end
    end else if (push) begin
      // When full, wr_ptr already points at the oldest entry, which is overwritten.
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        wr_ptr <= top_idx;
        count  <= count - CNT_W'(1);
      end
    end
  end

  // Storage is not reset; only the pointer/count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop && !empty) begin
        mem[top_idx] <= push_data;
      end else begin
        mem[wr_ptr] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with return-address stack and fetch handshake.
//   clk_150_mhz : core clock
//   pc_rst      : asynchronous active-high reset
//   bus         : control inputs, fetch handshake and stack status
//                 (see pc_unit_ras_if)
// The PC advances only on an accepted fetch. Next-PC priority:
// ret > call > jmp > taken jmp_if > sequential.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int                  RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input logic         clk_150_mhz,
  input logic         pc_rst,
  pc_unit_ras_if.slave bus
);

  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);

  logic [PC_WIDTH-1:0] pc;
  logic                fetch_valid_q;
  logic                accept;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] rel_pc;
  logic [PC_WIDTH-1:0] next_pc;
  pc_sel_t             pc_sel;

  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty;
  logic [PTR_W:0]      ras_count;
  logic                ras_overflow;
  logic                ras_underflow;

  assign accept = fetch_valid_q & bus.fetch_ready & ~bus.halt;

  // Additions wrap modulo 2^PC_WIDTH; no alignment correction is applied.
  assign seq_pc = pc + PC_WIDTH'(INSTR_BYTES);
  assign rel_pc = pc + bus.imm_padded_out;

  always_comb begin
    pc_sel = SEL_SEQ;
    if (bus.ret) begin
      // A return on an empty stack falls through to the sequential address.
      pc_sel = ras_empty ? SEL_SEQ : SEL_RAS;
    end else if (bus.call || bus.jmp || (bus.jmp_if && bus.alu_out_lsb)) begin
      pc_sel = SEL_REL;
    end
  end

  always_comb begin
    next_pc = seq_pc;
    case (pc_sel)
      SEL_REL: next_pc = rel_pc;
      SEL_RAS: next_pc = ras_top;
      default: next_pc = seq_pc;
    endcase
  end

  always_ff @(posedge clk_150_mhz or posedge pc_rst) begin
    if (pc_rst) begin
      fetch_valid_q <= 1'b0;
      pc            <= RESET_VECTOR;
    end else begin
      fetch_valid_q <= ~bus.halt;
      if (accept) begin
        pc <= next_pc;
      end
    end
  end

  ret_addr_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk_150_mhz),
    .rst       (pc_rst),
    .push      (accept & bus.call),
    .pop       (accept & bus.ret),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign bus.fetch_valid     = fetch_valid_q;
  assign bus.next_instr_addr = pc;
  assign bus.ras_count       = ras_count;
  assign bus.ras_overflow    = ras_overflow;
  assign bus.ras_underflow   = ras_underflow;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras with RESET_VECTOR=0x100, RAS_DEPTH=4.
module tb_pc_unit_ras;

  localparam int PC_WIDTH  = 32;
  localparam int RAS_DEPTH = 4;

  logic clk_150_mhz;
  logic pc_rst;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_pc;

  pc_unit_ras_if #(.PC_WIDTH(PC_WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_unit_ras #(
    .PC_WIDTH     (PC_WIDTH),
    .RESET_VECTOR (32'h100),
    .INSTR_BYTES  (4),
    .RAS_DEPTH    (RAS_DEPTH)
  ) dut (
    .clk_150_mhz (clk_150_mhz),
    .pc_rst      (pc_rst),
    .bus         (bus.slave)
  );

  // Clock / reset
  initial clk_150_mhz = 1'b0;
  always #5 clk_150_mhz = ~clk_150_mhz;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_150_mhz);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.halt = 0; bus.jmp = 0; bus.jmp_if = 0; bus.alu_out_lsb = 0;
    bus.call = 0; bus.ret = 0; bus.imm_padded_out = '0;
  endtask

  task automatic do_reset();
    pc_rst = 1;
    tick();
    pc_rst = 0;
    tick();
    exp_pc = 32'h100;
  endtask

  // Jump to an absolute address via a relative jmp from the modelled PC.
  task automatic goto(input logic [31:0] addr);
    clear_ctrl();
    bus.jmp = 1;
    bus.imm_padded_out = addr - exp_pc;
    tick();
    clear_ctrl();
    exp_pc = addr;
    tests_run++;
    if (bus.next_instr_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL goto: pc got %h expected %h", bus.next_instr_addr, exp_pc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] seq [3];
    seq[0] = 32'h100; seq[1] = 32'h104; seq[2] = 32'h108;
    pc_rst = 1;
    clear_ctrl();
    bus.fetch_ready = 1;
    #12;
    tests_run++;
    if (bus.next_instr_addr !== 32'h100 || bus.fetch_valid !== 1'b0 || bus.ras_count !== 3'd0 ||
        bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: pc %h fv %b cnt %0d ovf %b unf %b expected 100 0 0 0 0",
               bus.next_instr_addr, bus.fetch_valid, bus.ras_count, bus.ras_overflow, bus.ras_underflow);
    end
    @(posedge clk_150_mhz); #1;
    pc_rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (bus.fetch_valid !== 1'b1 || bus.next_instr_addr !== seq[i]) begin
        tests_failed++;
        $display("FAIL reset_seq[%0d]: fv %b pc %h expected 1 %h", i, bus.fetch_valid, bus.next_instr_addr, seq[i]);
      end
    end
    // call+ret on an empty stack: sequential target, entry pushed, underflow.
    bus.call = 1; bus.ret = 1; bus.imm_padded_out = 32'h40;
    tick();
    clear_ctrl();
    tests_run++;
    if (bus.next_instr_addr !== 32'h10C || bus.ras_count !== 3'd1 || bus.ras_underflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_swap: pc %h cnt %0d unf %b expected 10c 1 1",
               bus.next_instr_addr, bus.ras_count, bus.ras_underflow);
    end
    do_reset();
  endtask

  task automatic test_call_ret();
    goto(32'h200);
    bus.call = 1; bus.imm_padded_out = 32'h40;
    tick();
    clear_ctrl();
    tests_run++;
    if (bus.next_instr_addr !== 32'h240 || bus.ras_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL call: pc %h cnt %0d expected 240 1", bus.next_instr_addr, bus.ras_count);
    end
    tick(); tick();
    tests_run++;
    if (bus.next_instr_addr !== 32'h248) begin
      tests_failed++;
      $display("FAIL call_seq: pc %h expected 248", bus.next_instr_addr);
    end
    bus.ret = 1;
    tick();
    clear_ctrl();
    exp_pc = 32'h204;
    tests_run++;
    if (bus.next_instr_addr !== 32'h204 || bus.ras_count !== 3'd0 || bus.ras_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ret: pc %h cnt %0d unf %b expected 204 0 0",
               bus.next_instr_addr, bus.ras_count, bus.ras_underflow);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] ret_exp [5];
    ret_exp[0] = 32'h44; ret_exp[1] = 32'h34; ret_exp[2] = 32'h24;
    ret_exp[3] = 32'h14; ret_exp[4] = 32'h18;
    goto(32'h0);
    bus.call = 1; bus.imm_padded_out = 32'h10;
    for (int i = 0; i < 4; i++) tick();
    tests_run++;
    if (bus.ras_count !== 3'd4 || bus.ras_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ras_full: cnt %0d ovf %b expected 4 0", bus.ras_count, bus.ras_overflow);
    end
    tick();
    clear_ctrl();
    tests_run++;
    if (bus.next_instr_addr !== 32'h50 || bus.ras_count !== 3'd4 || bus.ras_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ras_overflow: pc %h cnt %0d ovf %b expected 50 4 1",
               bus.next_instr_addr, bus.ras_count, bus.ras_overflow);
    end
    bus.ret = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (bus.next_instr_addr !== ret_exp[i]) begin
        tests_failed++;
        $display("FAIL ras_ret[%0d]: pc %h expected %h", i, bus.next_instr_addr, ret_exp[i]);
      end
      if (i == 3) begin
        tests_run++;
        if (bus.ras_count !== 3'd0 || bus.ras_underflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ras_drained: cnt %0d unf %b expected 0 0", bus.ras_count, bus.ras_underflow);
        end
      end
    end
    clear_ctrl();
    exp_pc = 32'h18;
    tests_run++;
    if (bus.ras_underflow !== 1'b1 || bus.ras_count !== 3'd0 || bus.ras_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ras_underflow: unf %b cnt %0d ovf %b expected 1 0 1",
               bus.ras_underflow, bus.ras_count, bus.ras_overflow);
    end
  endtask

  task automatic test_stall_halt();
    bus.fetch_ready = 0;
    bus.jmp = 1; bus.imm_padded_out = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (bus.next_instr_addr !== exp_pc || bus.fetch_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall[%0d]: pc %h fv %b expected %h 1", i, bus.next_instr_addr, bus.fetch_valid, exp_pc);
      end
    end
    bus.fetch_ready = 1;
    tick();
    clear_ctrl();
    exp_pc = exp_pc + 32'h100;
    tests_run++;
    if (bus.next_instr_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL stall_release: pc %h expected %h", bus.next_instr_addr, exp_pc);
    end
    bus.halt = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (bus.next_instr_addr !== exp_pc || bus.fetch_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt[%0d]: pc %h fv %b expected %h 0", i, bus.next_instr_addr, bus.fetch_valid, exp_pc);
      end
    end
    bus.halt = 0;
    tick();
    tests_run++;
    if (bus.next_instr_addr !== exp_pc || bus.fetch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL unhalt: pc %h fv %b expected %h 1", bus.next_instr_addr, bus.fetch_valid, exp_pc);
    end
    tick();
    exp_pc = exp_pc + 32'h4;
    tests_run++;
    if (bus.next_instr_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL unhalt_adv: pc %h expected %h", bus.next_instr_addr, exp_pc);
    end
  endtask

  task automatic test_jmp_if_wrap();
    goto(32'h300);
    bus.jmp_if = 1; bus.alu_out_lsb = 0; bus.imm_padded_out = 32'hFFFF_FFF0;
    tick();
    clear_ctrl();
    tests_run++;
    if (bus.next_instr_addr !== 32'h304) begin
      tests_failed++;
      $display("FAIL jmp_if_not_taken: pc %h expected 304", bus.next_instr_addr);
    end
    exp_pc = 32'h304;
    goto(32'h300);
    bus.jmp_if = 1; bus.alu_out_lsb = 1; bus.imm_padded_out = 32'hFFFF_FFF0;
    tick();
    clear_ctrl();
    tests_run++;
    if (bus.next_instr_addr !== 32'h2F0) begin
      tests_failed++;
      $display("FAIL jmp_if_taken: pc %h expected 2f0", bus.next_instr_addr);
    end
    exp_pc = 32'h2F0;
    goto(32'hFFFF_FFFC);
    tick();
    exp_pc = 32'h0;
    tests_run++;
    if (bus.next_instr_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL pc_wrap: pc %h expected 0", bus.next_instr_addr);
    end
  endtask

  task automatic test_call_ret_swap();
    goto(32'h4FC);
    bus.call = 1; bus.imm_padded_out = 32'h80 - 32'h4FC;
    tick();
    tests_run++;
    if (bus.next_instr_addr !== 32'h80 || bus.ras_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL swap_setup: pc %h cnt %0d expected 80 1", bus.next_instr_addr, bus.ras_count);
    end
    bus.ret = 1;
    tick();
    tests_run++;
    if (bus.next_instr_addr !== 32'h500 || bus.ras_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL swap: pc %h cnt %0d expected 500 1", bus.next_instr_addr, bus.ras_count);
    end
    bus.call = 0;
    tick();
    clear_ctrl();
    exp_pc = 32'h84;
    tests_run++;
    if (bus.next_instr_addr !== 32'h84 || bus.ras_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL swap_top: pc %h cnt %0d expected 84 0", bus.next_instr_addr, bus.ras_count);
    end
  endtask

  task automatic test_async_reset();
    bus.call = 1; bus.imm_padded_out = 32'h20;
    tick();
    clear_ctrl();
    tick(); tick();
    @(posedge clk_150_mhz);
    #3;
    pc_rst = 1;
    #1;
    tests_run++;
    if (bus.next_instr_addr !== 32'h100 || bus.fetch_valid !== 1'b0 || bus.ras_count !== 3'd0 ||
        bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: pc %h fv %b cnt %0d ovf %b unf %b expected 100 0 0 0 0",
               bus.next_instr_addr, bus.fetch_valid, bus.ras_count, bus.ras_overflow, bus.ras_underflow);
    end
    @(posedge clk_150_mhz); #1;
    pc_rst = 0;
    tick();
    tick();
    tests_run++;
    if (bus.next_instr_addr !== 32'h104 || bus.fetch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset: pc %h fv %b expected 104 1", bus.next_instr_addr, bus.fetch_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_pc = 32'h100;
    pc_rst = 1;
    bus.fetch_ready = 1;
    clear_ctrl();
    test_reset();
    test_call_ret();
    test_ras_overflow();
    test_stall_halt();
    test_jmp_if_wrap();
    test_call_ret_swap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
